apuf_eval_ctrl: RTL
===================

// Module: apuf_eval_ctrl
// PURPOSE
//  Challenge/launch sequencer that sits directly upstream of the arbiter-PUF mux chain.
//  - Applies a latched challenge to the select lines of the chain.
//  - Fires a launch edge into both chain inputs, then samples the arbiter decision.
//  - Repeats NUM_EVAL times and reports a majority-voted response bit and a stability flag.
// PARAMETERS
//  CHAL_W      64  challenge width; one select bit per chain stage
//  SETTLE_CYC  4   cycles (>=1) of arbiter clear + select settling before each launch
//  CAPTURE_CYC 8   cycles (>=3) launch is held before the arbiter is sampled
//  NUM_EVAL    15  evaluations per challenge; must be odd, >=1
//  CNT_W       $clog2(NUM_EVAL+1)  derived width of the ones counter (localparam)
// PORTS
//  clk          in   1        single system clock
//  rst          in   1        asynchronous reset, active-high
//  chal_in      in   CHAL_W   challenge, sampled on an accepted start
//  start        in   1        request; accepted only when busy=0
//  busy         out  1        1 from the cycle after accept until the DONE cycle ends
//  chal_sel     out  CHAL_W   registered select lines to chain stages; stable while busy
//  launch       out  1        drive to both chain inputs; the rising edge races through the chain
//  arb_rst      out  1        arbiter clear, active-high
//  arb_out      in   1        arbiter decision, asynchronous to clk
//  resp         out  1        majority response
//  resp_valid   out  1        one-cycle pulse: resp, resp_stable and ones_cnt have been updated
//  resp_stable  out  1        1 when all NUM_EVAL samples agreed
//  ones_cnt     out  CNT_W    number of samples equal to 1 in the last run
// BEHAVIOUR
//  Reset (async, any state): state=IDLE; launch=0, arb_rst=1, busy=0; chal_sel=0;
//    resp, resp_valid, resp_stable, ones_cnt, counters and sync FFs =0.
//  arb_out passes through a 2-FF synchronizer (arb_s); all decisions use arb_s only.
//  All outputs are registered.
//  IDLE:    launch=0, arb_rst=1.
//           On start=1: chal_sel<=chal_in, eval_cnt<=0, acc<=0, timer<=SETTLE_CYC-1, busy<=1, go SETUP.
//  SETUP:   launch=0, arb_rst=1. When timer==0: timer<=CAPTURE_CYC-1, go LAUNCH; otherwise decrement.
//  LAUNCH:  launch=1, arb_rst=0. When timer==0 go SAMPLE; otherwise decrement.
//  SAMPLE:  one cycle; launch=1, arb_rst=0; acc<=acc+arb_s.
//           If eval_cnt==NUM_EVAL-1 go DONE; else eval_cnt++, timer<=SETTLE_CYC-1, go SETUP.
//  DONE:    one cycle; ones_cnt<=acc; resp<=(acc>NUM_EVAL/2);
//           resp_stable<=(acc==0 || acc==NUM_EVAL); resp_valid<=1 for exactly one cycle;
//           busy<=0; go IDLE.
//  Timing:  each evaluation is SETTLE_CYC+CAPTURE_CYC+1 cycles; launch is high CAPTURE_CYC+1
//           consecutive cycles per evaluation.
//  Latency: resp_valid is asserted NUM_EVAL*(SETTLE_CYC+CAPTURE_CYC+1)+1 cycles after the accept edge.
//  start while busy is ignored: no queueing, chal_sel unchanged.
//  start in the same cycle busy falls is also ignored; it is accepted from IDLE on the next cycle.
//  resp, resp_stable and ones_cnt hold their values until the next DONE.
//  acc never exceeds NUM_EVAL, so no wrap occurs.
//  Reset mid-run aborts the run: no resp_valid, previous results are cleared, launch drops immediately.
// TESTING (bench: NUM_EVAL=5, SETTLE_CYC=2, CAPTURE_CYC=4, CHAL_W=32; 7 cycles/eval, latency 36)
//  1. arb_out tied 1, start with chal_in=0xDEADBEEF -> chal_sel=0xDEADBEEF;
//     resp_valid 36 cycles after accept; resp=1, ones_cnt=5, resp_stable=1.
//  2. arb_out=1,0,1,0,1 per evaluation -> ones_cnt=3, resp=1, resp_stable=0.
//  3. arb_out=0,0,1,1,0 -> ones_cnt=2, resp=0, resp_stable=0; arb_out tied 0 -> ones_cnt=0, resp_stable=1.
//  4. Second start with chal_in=0x12345678 at cycle 10 of a run -> ignored; chal_sel stays 0xDEADBEEF;
//     exactly one resp_valid.
//  5. rst pulsed during LAUNCH of evaluation 3 -> launch=0, arb_rst=1, busy=0 without a clock edge;
//     no resp_valid; a new start then completes normally in 36 cycles.
//  6. Waveform check: per evaluation, arb_rst high for 2 cycles, then launch high for 5 cycles;
//     5 launch pulses per run; busy high for 37 cycles.

Source files
------------

// File: rtl/apuf_eval_ctrl_if.sv
// Handshake and chain-facing bundle for the arbiter-PUF evaluation sequencer.
// master = requester/chain side, slave = sequencer.
interface apuf_eval_ctrl_if #(
  parameter int CHAL_W = 64,
  parameter int CNT_W  = 4
);
  logic [CHAL_W-1:0] chal_in;
  logic              start;
  logic              busy;
  logic [CHAL_W-1:0] chal_sel;
  logic              launch;
  logic              arb_rst;
  logic              arb_out;
  logic              resp;
  logic              resp_valid;
  logic              resp_stable;
  logic [CNT_W-1:0]  ones_cnt;

  modport master (
    output chal_in, start, arb_out,
    input  busy, chal_sel, launch, arb_rst,
    input  resp, resp_valid, resp_stable, ones_cnt
  );

  modport slave (
    input  chal_in, start, arb_out,
    output busy, chal_sel, launch, arb_rst,
    output resp, resp_valid, resp_stable, ones_cnt
  );
endinterface

// File: rtl/apuf_eval_ctrl.sv
// Arbiter-PUF challenge/launch sequencer: repeated evaluation of one
// challenge with majority vote and stability flag on the response.
module apuf_eval_ctrl #(
  parameter int CHAL_W      = 64,
  parameter int SETTLE_CYC  = 4,
  parameter int CAPTURE_CYC = 8,
  parameter int NUM_EVAL    = 15
) (
  input  logic clk,
  input  logic rst,
  apuf_eval_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(NUM_EVAL + 1);
  localparam int TMR_W = $clog2(SETTLE_CYC + CAPTURE_CYC + 1);

  typedef enum logic [2:0] {
    IDLE, SETUP, LAUNCH, SAMPLE, DONE
  } state_t;

  state_t           state, state_n;
  logic [TMR_W-1:0] timer, timer_n;
  logic [CNT_W-1:0] eval_cnt, eval_cnt_n;
  logic [CNT_W-1:0] acc, acc_n;
  logic             sync1, arb_s;
  logic             accept;
  logic             fire_n;

  // busy is held through the result cycle, so a start there waits one cycle
  assign accept = (state == IDLE) && bus.start && !bus.busy;
  assign fire_n = (state_n == LAUNCH) || (state_n == SAMPLE);

  always_comb begin
    state_n    = state;
    timer_n    = timer;
    eval_cnt_n = eval_cnt;
    acc_n      = acc;
    unique case (state)
      IDLE: begin
        if (accept) begin
          state_n    = SETUP;
          timer_n    = TMR_W'(SETTLE_CYC - 1);
          eval_cnt_n = '0;
          acc_n      = '0;
        end
      end
      SETUP: begin
        if (timer == '0) begin
          state_n = LAUNCH;
          timer_n = TMR_W'(CAPTURE_CYC - 1);
        end else begin
          timer_n = timer - 1'b1;
        end
      end
      LAUNCH: begin
        if (timer == '0) state_n = SAMPLE;
        else             timer_n = timer - 1'b1;
      end
      SAMPLE: begin
        acc_n = acc + CNT_W'(arb_s);
        if (eval_cnt == CNT_W'(NUM_EVAL - 1)) begin
          state_n = DONE;
        end else begin
          state_n    = SETUP;
          eval_cnt_n = eval_cnt + 1'b1;
          timer_n    = TMR_W'(SETTLE_CYC - 1);
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      eval_cnt <= '0;
      acc      <= '0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      eval_cnt <= eval_cnt_n;
      acc      <= acc_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1           <= 1'b0;
      arb_s           <= 1'b0;
      bus.launch      <= 1'b0;
      bus.arb_rst     <= 1'b1;
      bus.busy        <= 1'b0;
      bus.chal_sel    <= '0;
      bus.resp        <= 1'b0;
      bus.resp_valid  <= 1'b0;
      bus.resp_stable <= 1'b0;
      bus.ones_cnt    <= '0;
    end else begin
      sync1          <= bus.arb_out;
      arb_s          <= sync1;
      bus.launch     <= fire_n;
      bus.arb_rst    <= !fire_n;
      bus.busy       <= (state != IDLE) || accept;
      bus.resp_valid <= (state == DONE);
      if (accept) bus.chal_sel <= bus.chal_in;
      if (state == DONE) begin
        bus.ones_cnt    <= acc;
        bus.resp        <= acc > CNT_W'(NUM_EVAL / 2);
        bus.resp_stable <= (acc == '0) || (acc == CNT_W'(NUM_EVAL));
      end
    end
  end

endmodule
